clkdiv_cfg_ctrl: RTL and testbench

Reconfiguration sequencer for the integer clock divider. It takes divide-ratio change requests from two requesters, arbitrates between them round-robin, and applies each change in a fixed order: gate the divider off, drain, load the new ratio, re-enable, wait for settle. It sits in the reference-clock domain next to the divider and drives the divider's enable and ratio inputs, so the ratio never changes while the divider is running.

---
 rtl/clkdiv_cfg_ctrl_if.sv | 15 +
 rtl/clkdiv_cfg_ctrl.sv | 103 ++++++++++
 tb/tb_clkdiv_cfg_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/clkdiv_cfg_ctrl_if.sv
// clkdiv_cfg_ctrl_if: request/ack and divider-control bundle for the ratio reconfiguration sequencer.
interface clkdiv_cfg_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       i_req;
    logic [WIDTH-1:0] i_ratio0;
    logic [WIDTH-1:0] i_ratio1;
    logic [1:0]       o_ack;
    logic [1:0]       o_nack;
    logic [WIDTH-1:0] o_div_ratio;
    logic             o_clk_en;
    logic             o_busy;
    modport master (output i_req, i_ratio0, i_ratio1, input o_ack, o_nack, o_div_ratio, o_clk_en, o_busy);
    modport slave  (input i_req, i_ratio0, i_ratio1, output o_ack, o_nack, o_div_ratio, o_clk_en, o_busy);
endinterface

// File: rtl/clkdiv_cfg_ctrl.sv
// clkdiv_cfg_ctrl: round-robin sequencer that gates, drains, reloads and settles the integer clock divider.
module clkdiv_cfg_ctrl #(
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int RESET_RATIO  = 1
) (
    input logic               i_clk_ref,
    input logic               i_rst,
    clkdiv_cfg_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, GRANT, DRAIN, LOAD, SETTLE, DONE} state_t;
    state_t           state, state_n;
    logic             rr, rr_n, gnt, gnt_n, en_n;
    logic [WIDTH-1:0] lat, lat_n, ratio_n, pick_ratio;
    logic [1:0]       ack_n, nack_n, req;
    logic [3:0]       dcnt, dcnt_n;
    logic [WIDTH:0]   scnt, scnt_n;
    logic             pick;
    // A requester still holding its level during its own ack/nack cycle must not be re-granted.
    assign req        = bus.i_req & ~(bus.o_ack | bus.o_nack);
    assign pick       = &req ? rr : req[1];
    assign pick_ratio = pick ? bus.i_ratio1 : bus.i_ratio0;
    always_comb begin
        state_n = state;
        rr_n    = rr;
        gnt_n   = gnt;
        lat_n   = lat;
        ratio_n = bus.o_div_ratio;
        en_n    = bus.o_clk_en;
        ack_n   = '0;
        nack_n  = '0;
        dcnt_n  = dcnt;
        scnt_n  = scnt;
        case (state)
            IDLE: state_n = |req ? GRANT : IDLE;
            GRANT: begin
                if (!(|req)) begin
                    state_n = IDLE;
                end else begin
                    gnt_n = pick;
                    lat_n = pick_ratio;
                    rr_n  = ~pick;
                    if (pick_ratio == '0) begin
                        nack_n  = pick ? 2'b10 : 2'b01;
                        state_n = IDLE;
                    end else if (pick_ratio == bus.o_div_ratio) begin
                        state_n = DONE;
                    end else begin
                        en_n    = 1'b0;
                        dcnt_n  = '0;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                dcnt_n  = dcnt + 4'd1;
                state_n = (dcnt == 4'(DRAIN_CYCLES - 1)) ? LOAD : DRAIN;
            end
            LOAD: begin
                ratio_n = lat;
                en_n    = lat >= WIDTH'(2);
                scnt_n  = '0;
                state_n = SETTLE;
            end
            SETTLE: begin
                scnt_n  = scnt + (WIDTH+1)'(1);
                state_n = (scnt == {lat, 1'b0} - (WIDTH+1)'(1)) ? DONE : SETTLE;
            end
            DONE: begin
                ack_n   = gnt ? 2'b10 : 2'b01;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk_ref) begin
        if (i_rst) begin
            state           <= IDLE;
            rr              <= 1'b0;
            gnt             <= 1'b0;
            lat             <= WIDTH'(RESET_RATIO);
            dcnt            <= '0;
            scnt            <= '0;
            bus.o_div_ratio <= WIDTH'(RESET_RATIO);
            bus.o_clk_en    <= 1'b0;
            bus.o_ack       <= '0;
            bus.o_nack      <= '0;
            bus.o_busy      <= 1'b0;
        end else begin
            state           <= state_n;
            rr              <= rr_n;
            gnt             <= gnt_n;
            lat             <= lat_n;
            dcnt            <= dcnt_n;
            scnt            <= scnt_n;
            bus.o_div_ratio <= ratio_n;
            bus.o_clk_en    <= en_n;
            bus.o_ack       <= ack_n;
            bus.o_nack      <= nack_n;
            bus.o_busy      <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// tb_clkdiv_cfg_ctrl: directed stimulus with a response scoreboard for the divider reconfiguration sequencer.
module tb_clkdiv_cfg_ctrl;
    localparam int W = 8;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    clkdiv_cfg_ctrl_if #(.WIDTH(W)) bus ();
    clkdiv_cfg_ctrl #(.WIDTH(W), .DRAIN_CYCLES(D), .RESET_RATIO(1)) dut (
        .i_clk_ref(clk),
        .i_rst    (rst),
        .bus      (bus)
    );
    typedef struct {
        logic [1:0]   ack;
        logic [1:0]   nack;
        int           cyc;
        logic [W-1:0] ratio;
        logic         en;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Expected latency from request to response, from the sequence timing.
    function automatic int delay(input int r, input int cur);
        return (r == 0) ? 2 : (r == cur) ? 3 : 4 + D + 2 * r;
    endfunction
    task automatic push(input logic [1:0] who, input logic is_nack, input int at, input int r, input logic en);
        exp_t x;
        x.ack   = is_nack ? 2'b00 : who;
        x.nack  = is_nack ? who : 2'b00;
        x.cyc   = at;
        x.ratio = W'(r);
        x.en    = en;
        sb.push_back(x);
    endtask
    always @(negedge clk) begin
        if ((bus.o_ack | bus.o_nack) != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {bus.o_ack, bus.o_nack}, 0);
            end else begin
                e = sb.pop_front();
                chk("ack", bus.o_ack, e.ack);
                chk("nack", bus.o_nack, e.nack);
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_ratio", bus.o_div_ratio, e.ratio);
                chk("resp_clk_en", bus.o_clk_en, e.en);
            end
        end
    end
    task automatic issue(input logic [1:0] r, input int r0, input int r1);
        bus.i_ratio0 = W'(r0);
        bus.i_ratio1 = W'(r1);
        bus.i_req    = r;
        n0           = cyc;
    endtask
    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            bus.i_req = bus.i_req & ~(bus.o_ack | bus.o_nack);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
            bus.i_req = 2'b00;
        end
        repeat (2) @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
    initial begin
        bus.i_req    = 2'b00;
        bus.i_ratio0 = '0;
        bus.i_ratio1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_clk_en", bus.o_clk_en, 0);
        chk("rst_ratio", bus.o_div_ratio, 1);
        chk("rst_ack", {bus.o_ack, bus.o_nack}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // single change 1 -> 6
        issue(2'b01, 6, 0);
        push(2'b01, 1'b0, n0 + delay(6, 1), 6, 1'b1);
        @(negedge clk);
        chk("single_busy", bus.o_busy, 1);
        @(negedge clk);
        chk("single_drain_en", bus.o_clk_en, 0);
        repeat (4) @(negedge clk);
        chk("single_load_old_ratio", bus.o_div_ratio, 1);
        @(negedge clk);
        chk("single_new_ratio", bus.o_div_ratio, 6);
        chk("single_new_en", bus.o_clk_en, 1);
        wait_idle(100);
        // same ratio: no gating
        issue(2'b01, 6, 0);
        push(2'b01, 1'b0, n0 + delay(6, 6), 6, 1'b1);
        repeat (2) @(negedge clk);
        chk("same_en_held", bus.o_clk_en, 1);
        wait_idle(20);
        // reject ratio 0 from requester 1
        issue(2'b10, 6, 0);
        push(2'b10, 1'b1, n0 + delay(0, 6), 6, 1'b1);
        wait_idle(20);
        // contention, pointer favours requester 0
        issue(2'b11, 4, 5);
        push(2'b01, 1'b0, n0 + delay(4, 6), 4, 1'b1);
        push(2'b10, 1'b0, n0 + delay(4, 6) + delay(5, 4), 5, 1'b1);
        wait_idle(100);
        // bypass
        issue(2'b01, 1, 5);
        push(2'b01, 1'b0, n0 + delay(1, 5), 1, 1'b0);
        repeat (2) @(negedge clk);
        chk("bypass_gate", bus.o_clk_en, 0);
        wait_idle(100);
        // contention again, pointer now favours requester 1
        issue(2'b11, 7, 3);
        push(2'b10, 1'b0, n0 + delay(3, 1), 3, 1'b1);
        push(2'b01, 1'b0, n0 + delay(3, 1) + delay(7, 3), 7, 1'b1);
        wait_idle(100);
        // max ratio, 510-cycle settle
        issue(2'b10, 7, 255);
        push(2'b10, 1'b0, n0 + delay(255, 7), 255, 1'b1);
        repeat (300) @(negedge clk);
        chk("max_settle_busy", bus.o_busy, 1);
        chk("max_ratio_loaded", bus.o_div_ratio, 255);
        wait_idle(700);
        // reset in the middle of SETTLE abandons the change silently
        issue(2'b01, 9, 0);
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", bus.o_busy, 1);
        chk("pre_rst_ratio", bus.o_div_ratio, 9);
        rst       = 1'b1;
        bus.i_req = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_clk_en", bus.o_clk_en, 0);
        chk("mid_rst_ratio", bus.o_div_ratio, 1);
        chk("mid_rst_busy", bus.o_busy, 0);
        repeat (40) @(negedge clk);
        chk("mid_rst_idle", bus.o_busy, 0);
        chk("leftover_expect", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
